// File: rtl/bitmap_frame_loader_pkg.sv
// Shared bitmap geometry, colour encoding, bitmap type and loader FSM states
// for the sprite bitmap writer (optional feature macro: BITMAP_MIRROR_X_EN).
package object_bitmap_pkg;

   localparam int OBJECT_NUMBER_OF_X_BITS = 5;
   localparam int OBJECT_NUMBER_OF_Y_BITS = 5;
   localparam int OBJECT_WIDTH_X          = 1 << OBJECT_NUMBER_OF_X_BITS;
   localparam int OBJECT_HEIGHT_Y         = 1 << OBJECT_NUMBER_OF_Y_BITS;
   localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

   typedef logic [OBJECT_NUMBER_OF_X_BITS-1:0] x_idx_t;
   typedef logic [OBJECT_NUMBER_OF_Y_BITS-1:0] y_idx_t;

   typedef logic [0:OBJECT_HEIGHT_Y-1][0:OBJECT_WIDTH_X-1][7:0] object_bitmap_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_SWAP
   } load_state_t;

   function automatic object_bitmap_t blank_bitmap();
      return object_bitmap_t'({(OBJECT_HEIGHT_Y * OBJECT_WIDTH_X){TRANSPARENT_ENCODING}});
   endfunction

endpackage

// File: rtl/bitmap_frame_loader_if.sv
// Pixel stream bus between a byte source (master) and the bitmap loader (slave).
// mirror_x exists only when BITMAP_MIRROR_X_EN is defined.
interface bitmap_frame_loader_if;

   logic       start_load;
   logic       pix_valid;
   logic [7:0] pix_data;
   logic       pix_ready;
`ifdef BITMAP_MIRROR_X_EN
   logic       mirror_x;
`endif

   modport master (
      input  pix_ready,
      output start_load, pix_valid, pix_data
`ifdef BITMAP_MIRROR_X_EN
      , mirror_x
`endif
   );

   modport slave (
      output pix_ready,
      input  start_load, pix_valid, pix_data
`ifdef BITMAP_MIRROR_X_EN
      , mirror_x
`endif
   );

endinterface

// File: rtl/bitmap_frame_loader_raster_counter.sv
// Raster-order write address generator: x fastest then y, optional column
// mirroring latched at load start, and a flag marking the last pixel position.
module bitmap_raster_counter
   import object_bitmap_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   i_clear,
   input  logic   i_advance,
   input  logic   i_mirror,
   output x_idx_t o_col,
   output y_idx_t o_row,
   output logic   o_last
);

   localparam x_idx_t X_LAST = x_idx_t'(OBJECT_WIDTH_X - 1);
   localparam y_idx_t Y_LAST = y_idx_t'(OBJECT_HEIGHT_Y - 1);

   x_idx_t r_x;
   y_idx_t r_y;
   logic   r_mirror;

   // NOTE: state updates use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x      <= '0;
         r_y      <= '0;
         r_mirror <= 1'b0;
      end else if (i_clear) begin
         r_x      <= '0;
         r_y      <= '0;
         r_mirror <= i_mirror;
      end else if (i_advance) begin
         // Power-of-two sizes: the final beat wraps both counters back to 0.
         r_x <= r_x + 1'b1;
         if (r_x == X_LAST) begin
            r_y <= r_y + 1'b1;
         end
      end
   end

   assign o_col  = r_mirror ? (X_LAST - r_x) : r_x;
   assign o_row  = r_y;
   assign o_last = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/bitmap_frame_loader.sv
// Double-buffered 32x32 sprite bitmap loader: fills a hidden back buffer from a
// pixel stream and swaps it visible on frame_start. Option: BITMAP_MIRROR_X_EN.
module bitmap_frame_loader
   import object_bitmap_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   bitmap_frame_loader_if.slave  bus,
   input  logic                  frame_start,
   output object_bitmap_t        object_colors,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  bitmap_valid
);

   load_state_t    r_state;
   load_state_t    w_next_state;
   object_bitmap_t r_buf0;
   object_bitmap_t r_buf1;
   logic           r_front_sel;
   logic           r_load_done;
   logic           r_bitmap_valid;

   logic   w_pix_ready;
   logic   w_start_acc;
   logic   w_accept;
   logic   w_swap;
   logic   w_last;
   logic   w_mirror;
   x_idx_t w_col;
   y_idx_t w_row;

`ifdef BITMAP_MIRROR_X_EN
   assign w_mirror = bus.mirror_x;
`else
   assign w_mirror = 1'b0;
`endif

   assign w_start_acc = (r_state == ST_IDLE) && bus.start_load;
   assign w_accept    = w_pix_ready && bus.pix_valid;
   assign w_swap      = (r_state == ST_WAIT_SWAP) && frame_start;

   bitmap_raster_counter u_raster (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_start_acc),
      .i_advance (w_accept),
      .i_mirror  (w_mirror),
      .o_col     (w_col),
      .o_row     (w_row),
      .o_last    (w_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:      if (bus.start_load)    w_next_state = ST_LOAD;
         ST_LOAD:      if (w_accept && w_last) w_next_state = ST_WAIT_SWAP;
         ST_WAIT_SWAP: if (frame_start)       w_next_state = ST_IDLE;
         default:                             w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pix_ready = 1'b0;
      load_busy   = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_pix_ready = 1'b1;
            load_busy   = 1'b1;
         end
         ST_WAIT_SWAP: load_busy = 1'b1;
         default: ;
      endcase
   end

   // NOTE: the buffers are flop arrays, not RAM macros, so they can be reset;
   // the transparent fill keeps drawers from showing garbage after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf0 <= blank_bitmap();
         r_buf1 <= blank_bitmap();
      end else if (w_accept) begin
         if (r_front_sel) begin
            r_buf0[w_row][w_col] <= bus.pix_data;
         end else begin
            r_buf1[w_row][w_col] <= bus.pix_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_front_sel    <= 1'b0;
         r_load_done    <= 1'b0;
         r_bitmap_valid <= 1'b0;
      end else begin
         r_load_done <= w_swap;
         if (w_swap) begin
            r_front_sel    <= ~r_front_sel;
            r_bitmap_valid <= 1'b1;
         end
      end
   end

   assign bus.pix_ready  = w_pix_ready;
   assign object_colors  = r_front_sel ? r_buf1 : r_buf0;
   assign load_done      = r_load_done;
   assign bitmap_valid   = r_bitmap_valid;

endmodule
